// File: rtl/dcache_port_arbiter.sv
// Two-port arbiter/sequencer in front of the single-port data cache.
// Define DCACHE_ARB_FIXED_PRIO_EN for fixed port-0 priority instead of round-robin.
module dcache_port_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int RD_LATENCY = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              m0_req,
  input  logic              m0_we,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  output logic              m0_gnt,
  output logic              m0_rsp_valid,
  output logic              m0_rsp_err,
  output logic [DATA_W-1:0] m0_rdata,
  input  logic              m1_req,
  input  logic              m1_we,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic              m1_gnt,
  output logic              m1_rsp_valid,
  output logic              m1_rsp_err,
  output logic [DATA_W-1:0] m1_rdata,
  output logic [ADDR_W-1:0] dCacheAddr,
  output logic              dCacheWriteEn,
  output logic              dCacheReadEn,
  output logic [DATA_W-1:0] dCacheWriteData,
  input  logic [DATA_W-1:0] dCacheReadData,
  output logic              busy
);

  localparam int CNT_W = (RD_LATENCY > 1) ? $clog2(RD_LATENCY) : 1;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t           state, state_nx;
  logic             owner, we_q, err_q;
  logic [CNT_W-1:0] cnt;
  logic             sel, any_req, misaligned, last_cycle;
`ifndef DCACHE_ARB_FIXED_PRIO_EN
  logic             last_owner;
`endif

  assign any_req = m0_req | m1_req;
  assign busy    = (state != IDLE);

  always_comb begin
`ifdef DCACHE_ARB_FIXED_PRIO_EN
    sel = ~m0_req;
`else
    sel = (m0_req & m1_req) ? ~last_owner : m1_req;
`endif
    misaligned = sel ? (m1_addr[1:0] != 2'b00) : (m0_addr[1:0] != 2'b00);
    // Read data is sampled at the end of the final ISSUE/WAIT cycle.
    last_cycle = ((state == ISSUE) && (RD_LATENCY == 1)) ||
                 ((state == WAIT) && (cnt == CNT_W'(1)));
  end

  always_comb begin
    state_nx      = state;
    m0_gnt        = 1'b0;
    m1_gnt        = 1'b0;
    dCacheWriteEn = 1'b0;
    dCacheReadEn  = 1'b0;
    m0_rsp_valid  = 1'b0;
    m0_rsp_err    = 1'b0;
    m1_rsp_valid  = 1'b0;
    m1_rsp_err    = 1'b0;
    case (state)
      IDLE: begin
        if (any_req) begin
          m0_gnt   = ~sel;
          m1_gnt   = sel;
          state_nx = misaligned ? RESP : ISSUE;
        end
      end
      ISSUE: begin
        dCacheWriteEn = we_q;
        dCacheReadEn  = ~we_q;
        state_nx      = (RD_LATENCY > 1) ? WAIT : RESP;
      end
      WAIT: begin
        if (cnt == CNT_W'(1)) state_nx = RESP;
      end
      RESP: begin
        m0_rsp_valid = ~owner;
        m0_rsp_err   = ~owner & err_q;
        m1_rsp_valid = owner;
        m1_rsp_err   = owner & err_q;
        state_nx     = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state           <= IDLE;
      owner           <= 1'b0;
      we_q            <= 1'b0;
      err_q           <= 1'b0;
      cnt             <= '0;
      dCacheAddr      <= '0;
      dCacheWriteData <= '0;
      m0_rdata        <= '0;
      m1_rdata        <= '0;
`ifndef DCACHE_ARB_FIXED_PRIO_EN
      last_owner      <= 1'b1;
`endif
    end else begin
      state <= state_nx;
      if ((state == IDLE) && any_req) begin
        owner <= sel;
        we_q  <= sel ? m1_we : m0_we;
        err_q <= misaligned;
`ifndef DCACHE_ARB_FIXED_PRIO_EN
        last_owner <= sel;
`endif
        // Misaligned accesses never reach the cache, so its bus keeps its old value.
        if (!misaligned) begin
          dCacheAddr <= sel ? m1_addr : m0_addr;
          if (sel ? m1_we : m0_we) dCacheWriteData <= sel ? m1_wdata : m0_wdata;
        end
      end
      if (state == ISSUE)     cnt <= CNT_W'(RD_LATENCY - 1);
      else if (state == WAIT) cnt <= cnt - CNT_W'(1);
      if (last_cycle && !we_q) begin
        if (owner) m1_rdata <= dCacheReadData;
        else       m0_rdata <= dCacheReadData;
      end
    end
  end

endmodule

// File: tb/tb_dcache_port_arbiter.sv
// Directed bench for dcache_port_arbiter: one instance at RD_LATENCY=1, one at RD_LATENCY=3.
module tb_dcache_port_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Instance A: RD_LATENCY=1
  logic        a_m0_req = 0, a_m0_we = 0, a_m1_req = 0, a_m1_we = 0;
  logic [31:0] a_m0_addr = 0, a_m0_wdata = 0, a_m1_addr = 0, a_m1_wdata = 0;
  logic        a_m0_gnt, a_m0_rsp_valid, a_m0_rsp_err, a_m1_gnt, a_m1_rsp_valid, a_m1_rsp_err;
  logic [31:0] a_m0_rdata, a_m1_rdata, a_addr, a_wdata;
  logic [31:0] a_rd = 32'hDEADBEEF;
  logic        a_we_en, a_rd_en, a_busy;

  // Instance B: RD_LATENCY=3
  logic        b_m0_req = 0, b_m0_we = 0, b_m1_req = 0, b_m1_we = 0;
  logic [31:0] b_m0_addr = 0, b_m0_wdata = 0, b_m1_addr = 0, b_m1_wdata = 0;
  logic        b_m0_gnt, b_m0_rsp_valid, b_m0_rsp_err, b_m1_gnt, b_m1_rsp_valid, b_m1_rsp_err;
  logic [31:0] b_m0_rdata, b_m1_rdata, b_addr, b_wdata;
  logic [31:0] b_rd = 32'hFFFF0000;
  logic        b_we_en, b_rd_en, b_busy;

  dcache_port_arbiter #(.ADDR_W(32), .DATA_W(32), .RD_LATENCY(1)) u_dut_a (
    .clk(clk), .rst(rst),
    .m0_req(a_m0_req), .m0_we(a_m0_we), .m0_addr(a_m0_addr), .m0_wdata(a_m0_wdata),
    .m0_gnt(a_m0_gnt), .m0_rsp_valid(a_m0_rsp_valid), .m0_rsp_err(a_m0_rsp_err), .m0_rdata(a_m0_rdata),
    .m1_req(a_m1_req), .m1_we(a_m1_we), .m1_addr(a_m1_addr), .m1_wdata(a_m1_wdata),
    .m1_gnt(a_m1_gnt), .m1_rsp_valid(a_m1_rsp_valid), .m1_rsp_err(a_m1_rsp_err), .m1_rdata(a_m1_rdata),
    .dCacheAddr(a_addr), .dCacheWriteEn(a_we_en), .dCacheReadEn(a_rd_en),
    .dCacheWriteData(a_wdata), .dCacheReadData(a_rd), .busy(a_busy)
  );

  dcache_port_arbiter #(.ADDR_W(32), .DATA_W(32), .RD_LATENCY(3)) u_dut_b (
    .clk(clk), .rst(rst),
    .m0_req(b_m0_req), .m0_we(b_m0_we), .m0_addr(b_m0_addr), .m0_wdata(b_m0_wdata),
    .m0_gnt(b_m0_gnt), .m0_rsp_valid(b_m0_rsp_valid), .m0_rsp_err(b_m0_rsp_err), .m0_rdata(b_m0_rdata),
    .m1_req(b_m1_req), .m1_we(b_m1_we), .m1_addr(b_m1_addr), .m1_wdata(b_m1_wdata),
    .m1_gnt(b_m1_gnt), .m1_rsp_valid(b_m1_rsp_valid), .m1_rsp_err(b_m1_rsp_err), .m1_rdata(b_m1_rdata),
    .dCacheAddr(b_addr), .dCacheWriteEn(b_we_en), .dCacheReadEn(b_rd_en),
    .dCacheWriteData(b_wdata), .dCacheReadData(b_rd), .busy(b_busy)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic drive_edge();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1);
  end

  logic [3:0] exp_order;
  int ng, n, cyc, rsp_seen;

  initial begin
`ifdef DCACHE_ARB_FIXED_PRIO_EN
    exp_order = 4'b0000;
`else
    exp_order = 4'b1010;
`endif
    // Reset state
    repeat (2) @(negedge clk);
    check("rst_busy", a_busy, 0);
    check("rst_strobes", {a_we_en, a_rd_en, b_we_en, b_rd_en}, 0);
    check("rst_addr", a_addr, 0);
    check("rst_wdata", a_wdata, 0);
    check("rst_rdata", a_m0_rdata | a_m1_rdata, 0);
    check("rst_rsp", {a_m0_rsp_valid, a_m0_rsp_err, a_m1_rsp_valid, a_m1_rsp_err}, 0);
    rst = 1'b0;

    // m0 read 0x10, latency 1
    drive_edge();
    a_m0_req = 1; a_m0_we = 0; a_m0_addr = 32'h10;
    @(negedge clk);
    check("rd_gnt", {a_m0_gnt, a_m1_gnt}, 2'b10);
    drive_edge(); a_m0_req = 0;
    @(negedge clk);
    check("rd_issue_en", {a_rd_en, a_we_en}, 2'b10);
    check("rd_issue_addr", a_addr, 32'h10);
    check("rd_issue_norsp", a_m0_rsp_valid, 0);
    @(negedge clk);
    check("rd_rsp", {a_m0_rsp_valid, a_m0_rsp_err, a_m1_rsp_valid}, 3'b100);
    check("rd_rdata", a_m0_rdata, 32'hDEADBEEF);
    check("rd_rsp_strobes", {a_rd_en, a_we_en}, 0);
    @(negedge clk);
    check("rd_idle", {a_busy, a_m0_rsp_valid}, 0);

    // m1 write 0x20
    drive_edge();
    a_m1_req = 1; a_m1_we = 1; a_m1_addr = 32'h20; a_m1_wdata = 32'h12345678;
    @(negedge clk);
    check("wr_gnt", {a_m0_gnt, a_m1_gnt}, 2'b01);
    drive_edge(); a_m1_req = 0;
    @(negedge clk);
    check("wr_issue_en", {a_we_en, a_rd_en}, 2'b10);
    check("wr_issue_data", a_wdata, 32'h12345678);
    check("wr_issue_addr", a_addr, 32'h20);
    @(negedge clk);
    check("wr_rsp", {a_m1_rsp_valid, a_m1_rsp_err}, 2'b10);
    check("wr_m0_idle", {a_m0_rsp_valid, a_m0_rsp_err}, 0);
    check("wr_m0_rdata_hold", a_m0_rdata, 32'hDEADBEEF);
    check("wr_strobes_off", {a_we_en, a_rd_en}, 0);
    check("wr_wdata_hold", a_wdata, 32'h12345678);

    // Both requesting continuously from reset
    drive_edge(); rst = 1;
    @(negedge clk); rst = 0;
    drive_edge();
    a_m0_req = 1; a_m1_req = 1; a_m0_we = 0; a_m1_we = 0;
    a_m0_addr = 32'h30; a_m1_addr = 32'h30;
    ng = 0; cyc = 0;
    while (ng < 4 && cyc < 40) begin
      @(negedge clk);
      cyc++;
      if (a_m0_gnt || a_m1_gnt) begin
        check("arb_one_gnt", {a_m0_gnt, a_m1_gnt} == 2'b11, 0);
        check($sformatf("arb_order%0d", ng), a_m1_gnt, exp_order[ng]);
        ng++;
      end
    end
    check("arb_count", ng, 4);
    drive_edge(); a_m0_req = 0; a_m1_req = 0;
    n = 0;
    while (a_busy && n < 10) begin @(negedge clk); n++; end
    check("arb_drain", a_busy, 0);

    // m0 misaligned read 0x13
    a_rd = 32'hCAFEF00D;
    drive_edge();
    a_m0_req = 1; a_m0_we = 0; a_m0_addr = 32'h13;
    @(negedge clk);
    check("mis_gnt", a_m0_gnt, 1);
    drive_edge(); a_m0_req = 0;
    @(negedge clk);
    check("mis_rsp", {a_m0_rsp_valid, a_m0_rsp_err}, 2'b11);
    check("mis_nostrobe", {a_we_en, a_rd_en}, 0);
    check("mis_rdata_hold", a_m0_rdata, 32'hDEADBEEF);
    check("mis_addr_hold", a_addr, 32'h30);
    @(negedge clk);
    check("mis_idle", {a_busy, a_m0_rsp_valid, a_m0_rsp_err}, 0);

    // Latency 3: m0 read 0x40, m1 write raised at T+1
    drive_edge();
    b_m0_req = 1; b_m0_we = 0; b_m0_addr = 32'h40;
    @(negedge clk);
    check("l3_gnt", {b_m0_gnt, b_m1_gnt}, 2'b10);
    drive_edge();
    b_m0_req = 0; b_m1_req = 1; b_m1_we = 1; b_m1_addr = 32'h44; b_m1_wdata = 32'h77;
    @(negedge clk);
    check("l3_t1", {b_rd_en, b_we_en, b_m1_gnt}, 3'b100);
    check("l3_t1_addr", b_addr, 32'h40);
    @(negedge clk);
    check("l3_t2", {b_rd_en, b_we_en, b_m1_gnt, b_busy}, 4'b0001);
    check("l3_t2_addr", b_addr, 32'h40);
    drive_edge(); b_rd = 32'hA5A50040;
    @(negedge clk);
    check("l3_t3", {b_rd_en, b_m0_rsp_valid, b_m1_gnt}, 0);
    check("l3_t3_addr", b_addr, 32'h40);
    drive_edge(); b_rd = 32'hFFFF0000;
    @(negedge clk);
    check("l3_rsp", {b_m0_rsp_valid, b_m0_rsp_err, b_m1_gnt}, 3'b100);
    check("l3_rdata", b_m0_rdata, 32'hA5A50040);
    @(negedge clk);
    check("l3_m1_gnt", {b_m1_gnt, b_busy}, 2'b10);
    drive_edge(); b_m1_req = 0;
    @(negedge clk);
    check("l3_wr_issue", {b_we_en, b_rd_en}, 2'b10);
    check("l3_wr_data", b_wdata, 32'h77);
    n = 0;
    while (!b_m1_rsp_valid && n < 6) begin @(negedge clk); n++; end
    check("l3_wr_lat", n, 3);
    check("l3_m1_rdata_hold", b_m1_rdata, 0);
    @(negedge clk);
    check("l3_wr_idle", b_busy, 0);

    // Reset during WAIT
    drive_edge();
    b_m0_req = 1; b_m0_we = 0; b_m0_addr = 32'h48;
    @(negedge clk);
    check("rw_gnt", b_m0_gnt, 1);
    drive_edge(); b_m0_req = 0;
    repeat (2) @(negedge clk);
    check("rw_in_wait", {b_busy, b_rd_en}, 2'b10);
    rst = 1;
    #1;
    check("rw_busy", b_busy, 0);
    check("rw_strobes", {b_rd_en, b_we_en}, 0);
    check("rw_addr", b_addr, 0);
    check("rw_rdata", b_m0_rdata, 0);
    check("rw_a_rdata", a_m0_rdata, 0);
    repeat (2) @(negedge clk);
    rst = 0;
    rsp_seen = 0;
    repeat (6) begin
      @(negedge clk);
      if (b_m0_rsp_valid || b_m1_rsp_valid) rsp_seen++;
    end
    check("rw_no_rsp", rsp_seen, 0);
    drive_edge();
    b_m1_req = 1; b_m1_we = 0; b_m1_addr = 32'h50;
    @(negedge clk);
    check("rw_regnt", {b_m0_gnt, b_m1_gnt}, 2'b01);
    drive_edge(); b_m1_req = 0;
    n = 0;
    while (b_busy && n < 10) begin @(negedge clk); n++; end
    check("rw_drain", b_busy, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/dcache_port_arbiter.md
Name: dcache_port_arbiter

Overview:
Two-requester arbiter and access sequencer for the single-port data cache. Port 0 serves the memory-access pipeline stage (LW/SW). Port 1 serves a secondary master (debug loader / DMA fill).
- Grants one access at a time, drives the dCache control signals, waits the cache read latency, and returns a per-port response pulse.
- Rejects misaligned word accesses with an error response instead of touching the cache.

Parameters:
ADDR_W, 32, address width in bits
DATA_W, 32, data width in bits
RD_LATENCY, 1, cycles from dCache enable to valid dCacheReadData (>=1)

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
m0_req  in  1  port 0 request, held until m0_gnt
m0_we  in  1  port 0 write (1) / read (0)
m0_addr  in  ADDR_W  port 0 byte address
m0_wdata  in  DATA_W  port 0 store data
m0_gnt  out  1  port 0 request accepted this cycle
m0_rsp_valid  out  1  port 0 response pulse
m0_rsp_err  out  1  port 0 misaligned error, valid with rsp_valid
m0_rdata  out  DATA_W  port 0 load data, valid with rsp_valid on reads
m1_req, m1_we, m1_addr, m1_wdata, m1_gnt, m1_rsp_valid, m1_rsp_err, m1_rdata  as port 0, for port 1
dCacheAddr  out  ADDR_W  cache address
dCacheWriteEn  out  1  cache write strobe
dCacheReadEn  out  1  cache read strobe
dCacheWriteData  out  DATA_W  cache write data
dCacheReadData  in  DATA_W  cache read data
busy  out  1  high in any state other than IDLE

Behaviour:
- Reset (asynchronous, rst=1):
  - state=IDLE; last_owner=1, so port 0 wins the first tie.
  - All outputs 0, including the dCache outputs and both rdata buses.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - If any req: select owner. m*_gnt is combinational, high only in IDLE, and only for the selected port.
  - On the grant edge, latch owner, we, addr and wdata.
  - Next state: ISSUE, or RESP with err=1 if addr[1:0]!=0.
- Arbitration:
  - Single request: that port wins.
  - Both requesting: the port != last_owner wins. last_owner updates on every grant.
- ISSUE (1 cycle):
  - dCacheAddr=latched addr.
  - Write: dCacheWriteEn=1, dCacheWriteData=wdata.
  - Read: dCacheReadEn=1.
  - Strobes are high in ISSUE only.
  - Next state: WAIT if RD_LATENCY>1, else RESP.
- WAIT:
  - Lasts RD_LATENCY-1 cycles, counted with a down-counter.
  - dCacheAddr and dCacheWriteData are held; strobes are 0.
- Read data capture: dCacheReadData is captured at the end of the last ISSUE/WAIT cycle.
- RESP (1 cycle):
  - Owner's rsp_valid=1, with rsp_err as latched.
  - Owner's rdata = captured data on an error-free read; unchanged on writes and errors.
  - Next state: IDLE.
- Timing, grant at cycle T:
  - Normal access: rsp_valid at T+RD_LATENCY+1, next grant possible at T+RD_LATENCY+2.
  - Misaligned access: rsp_valid at T+1, and no dCache strobe is asserted.
- Requests arriving during ISSUE/WAIT/RESP: ignored (no gnt) until IDLE. The requester holds req.
- Non-owner outputs: rsp_valid and rsp_err stay 0; rdata holds its last value.
- Reset mid-operation: the transaction is abandoned with no response. Strobes drop immediately (asynchronous).
- dCache outputs outside ISSUE/WAIT: strobes 0; dCacheAddr/dCacheWriteData hold their last value.

Optional Feature:
- Macro: DCACHE_ARB_FIXED_PRIO_EN.
- Defined: port 0 always wins ties; last_owner is unused (pipeline-first priority).
- Undefined: round-robin as specified above.
- Both modes: single-request behaviour, timing and all other rules are identical.

Test Plan:
- Reset, then m0 read addr 0x10, cache returns 0xDEADBEEF, RD_LATENCY=1:
  - m0_gnt at T, dCacheReadEn=1 and dCacheAddr=0x10 at T+1.
  - m0_rsp_valid=1, m0_rdata=0xDEADBEEF at T+2, busy=0 at T+3.
- m1 write addr 0x20, wdata 0x12345678:
  - At T+1: dCacheWriteEn=1, dCacheWriteData=0x12345678, dCacheReadEn=0.
  - At T+2: m1_rsp_valid=1, m1_rsp_err=0, m0 outputs idle.
- m0 and m1 request continuously from reset:
  - Round-robin: grant order 0,1,0,1.
  - With DCACHE_ARB_FIXED_PRIO_EN: grant order 0,0,0,0.
- m0 read addr 0x13 (misaligned):
  - m0_rsp_valid=1, m0_rsp_err=1 at T+1; no dCache strobe; m0_rdata unchanged.
- RD_LATENCY=3, m0 read addr 0x40:
  - dCacheReadEn pulses 1 cycle at T+1; dCacheAddr=0x40 held T+1..T+3.
  - rsp_valid at T+4; an m1 req raised at T+1 is granted at T+5.
- rst asserted during WAIT:
  - All outputs 0 immediately; no rsp_valid afterwards.
  - First request after release is granted in IDLE.
